// File: rtl/jt900h_fetch_pkg.sv
// Shared constants for the 900H instruction prefetch front end:
// fetch size encodings, fetch FSM state codes and the default reset PC.
package jt900h_fetch_pkg;

    localparam logic [23:0] DEF_RST_PC = 24'hFF0000;

    localparam logic [1:0] FSEL_1B = 2'd0;
    localparam logic [1:0] FSEL_2B = 2'd1;
    localparam logic [1:0] FSEL_3B = 2'd2;
    localparam logic [1:0] FSEL_4B = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_t;

    function automatic logic [2:0] fsel_bytes(input logic [1:0] sel);
        logic [2:0] n;
        n = 3'd1;
        case (sel)
            FSEL_1B: n = 3'd1;
            FSEL_2B: n = 3'd2;
            FSEL_3B: n = 3'd3;
            FSEL_4B: n = 3'd4;
            default: n = 3'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jt900h_pfq.sv
// Prefetch byte queue: circular buffer taking 1 or 2 bytes per push,
// releasing 1-4 bytes per pop and exposing the four head bytes.
module jt900h_pfq #(
    parameter int QDEPTH = 8
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cen,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     push_hi,
    input  logic [15:0]              din,
    input  logic                     pop,
    input  logic [2:0]               pop_n,
    output logic [$clog2(QDEPTH):0]  count,
    output logic [31:0]              op
);
    localparam int AW = $clog2(QDEPTH);

    logic [7:0]    mem [QDEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   push_amt;
    logic [AW:0]   pop_amt;

    always_comb begin
        push_amt = '0;
        pop_amt  = '0;
        if (push) push_amt = push_hi ? (AW+1)'(1) : (AW+1)'(2);
        if (pop)  pop_amt  = (AW+1)'(pop_n);
    end

    // Pointers wrap naturally because QDEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (cen) begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                rd_ptr <= rd_ptr + AW'(pop_amt);
                wr_ptr <= wr_ptr + AW'(push_amt);
                count  <= count + push_amt - pop_amt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cen && push && !flush) begin
            if (push_hi) begin
                mem[wr_ptr] <= din[15:8];
            end else begin
                mem[wr_ptr]            <= din[7:0];
                mem[wr_ptr + AW'(1)]   <= din[15:8];
            end
        end
    end

    always_comb begin
        op = '0;
        for (int i = 0; i < 4; i++) begin
            op[8*i +: 8] = mem[rd_ptr + AW'(i)];
        end
    end

endmodule

// File: rtl/jt900h_fetch.sv
// Instruction fetch unit: keeps the prefetch queue topped up from a 16-bit
// bus and tracks the PC of the head byte. QDEPTH must be a power of two >= 4.
module jt900h_fetch import jt900h_fetch_pkg::*; #(
    parameter logic [23:0] RST_PC = DEF_RST_PC,
    parameter int          QDEPTH = 8
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        inc_pc,
    input  logic [1:0]  fetch_sel,
    input  logic        pc_load,
    input  logic [23:0] pc_nx,
    output logic [7:0]  md,
    output logic [31:0] op,
    output logic [23:0] pc,
    output logic        mem_busy,
    output logic [23:0] bus_addr,
    output logic        bus_rd,
    input  logic [15:0] bus_din,
    input  logic        bus_ack
);
    localparam int          AW         = $clog2(QDEPTH);
    localparam logic [AW:0] FILL_LIMIT = (AW+1)'(QDEPTH - 2);

    fetch_state_t state, state_nx;
    logic [23:0]  faddr;
    logic [AW:0]  count;
    logic [2:0]   pop_n;
    logic         push;
    logic         pop;

    always_comb begin
        pop_n    = fsel_bytes(fetch_sel);
        mem_busy = count < (AW+1)'(pop_n);
        pop      = inc_pc && !mem_busy && !pc_load;
        push     = 1'b0;
        bus_rd   = 1'b0;
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (!pc_load && count <= FILL_LIMIT) state_nx = ST_REQ;
            end
            ST_REQ: begin
                bus_rd = 1'b1;
                // A jump kills the outstanding read; a same-cycle ack is simply dropped
                if (pc_load) begin
                    state_nx = bus_ack ? ST_IDLE : ST_DISCARD;
                end else if (bus_ack) begin
                    push     = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            ST_DISCARD: begin
                bus_rd = 1'b1;
                if (bus_ack) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // bus_addr is latched at request issue so it stays put even if a jump
    // moves faddr while the stale read is still outstanding
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            pc       <= RST_PC;
            faddr    <= RST_PC;
            bus_addr <= {RST_PC[23:1], 1'b0};
        end else if (cen) begin
            state <= state_nx;
            if (pc_load) begin
                pc    <= pc_nx;
                faddr <= pc_nx;
            end else begin
                if (pop)  pc    <= pc + 24'(pop_n);
                if (push) faddr <= {faddr[23:1] + 23'd1, 1'b0};
            end
            if (state == ST_IDLE && state_nx == ST_REQ) bus_addr <= {faddr[23:1], 1'b0};
        end
    end

    jt900h_pfq #(.QDEPTH(QDEPTH)) u_pfq (
        .clk     (clk),
        .rst     (rst),
        .cen     (cen),
        .flush   (pc_load),
        .push    (push),
        .push_hi (faddr[0]),
        .din     (bus_din),
        .pop     (pop),
        .pop_n   (pop_n),
        .count   (count),
        .op      (op)
    );

    assign md = op[7:0];

endmodule

// File: tb/tb_jt900h_fetch.sv
// Directed bench for jt900h_fetch: a table of pop vectors on a full queue
// plus hand-written sequences for jumps, odd targets and push/pop overlap.
module tb_jt900h_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b1;
    logic        inc_pc = 1'b0;
    logic [1:0]  fetch_sel = 2'd0;
    logic        pc_load = 1'b0;
    logic [23:0] pc_nx = 24'd0;
    logic [7:0]  md;
    logic [31:0] op;
    logic [23:0] pc;
    logic        mem_busy;
    logic [23:0] bus_addr;
    logic        bus_rd;
    logic [15:0] bus_din;
    logic        bus_ack;

    logic        resp_en = 1'b0;
    logic        resp_ack = 1'b0;
    logic [15:0] resp_din = 16'd0;
    int          resp_wait = 0;
    logic        man_ack = 1'b0;
    logic [15:0] man_din = 16'd0;
    logic [23:0] ack_addr [16];
    int          n_acks = 0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        inc;
        logic [1:0]  sel;
        logic        exp_busy;
        logic        exp_rd;
        logic [23:0] exp_pc;
        logic [31:0] exp_op;
        logic [31:0] op_mask;
    } vec_t;

    vec_t vecs [7];

    assign bus_ack = resp_en ? resp_ack : man_ack;
    assign bus_din = resp_en ? resp_din : man_din;

    jt900h_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .inc_pc    (inc_pc),
        .fetch_sel (fetch_sel),
        .pc_load   (pc_load),
        .pc_nx     (pc_nx),
        .md        (md),
        .op        (op),
        .pc        (pc),
        .mem_busy  (mem_busy),
        .bus_addr  (bus_addr),
        .bus_rd    (bus_rd),
        .bus_din   (bus_din),
        .bus_ack   (bus_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        logic [3:0] n;
        n = a[3:0] + 4'd1;
        return {n, n};
    endfunction

    function automatic logic [15:0] mem_word(input logic [23:0] a);
        logic [23:0] e;
        e = {a[23:1], 1'b0};
        return {mem_byte(e | 24'd1), mem_byte(e)};
    endfunction

    // Memory model: acks one cycle after it first sees a request
    always @(negedge clk) begin
        if (resp_ack) begin
            resp_ack <= 1'b0;
        end else if (resp_en && bus_rd) begin
            if (resp_wait >= 1) begin
                resp_ack  <= 1'b1;
                resp_din  <= mem_word(bus_addr);
                resp_wait <= 0;
                if (n_acks < 16) ack_addr[n_acks] <= bus_addr;
                n_acks <= n_acks + 1;
            end else begin
                resp_wait <= resp_wait + 1;
            end
        end else begin
            resp_wait <= 0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic inc, input logic [1:0] sel);
        inc_pc    = inc;
        fetch_sel = sel;
        pc_load   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic waitBusRd(input string name);
        int n;
        n = 0;
        while (bus_rd !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput({name, " bus_rd wait"}, {31'd0, bus_rd}, 32'd1);
    endtask

    task automatic ackCycle(input string name, input logic [23:0] exp_addr, input logic [15:0] data,
                            input logic inc, input logic [1:0] sel);
        waitBusRd(name);
        checkOutput({name, " bus_addr"}, {8'd0, bus_addr}, {8'd0, exp_addr});
        man_din   = data;
        man_ack   = 1'b1;
        inc_pc    = inc;
        fetch_sel = sel;
        @(posedge clk);
        #1;
        man_ack = 1'b0;
    endtask

    initial begin
        int n;

        vecs[0] = '{1'b1, 2'd1, 1'b0, 1'b0, 24'hFF0000, 32'h44332211, 32'hFFFFFFFF};
        vecs[1] = '{1'b1, 2'd1, 1'b0, 1'b0, 24'hFF0002, 32'h66554433, 32'hFFFFFFFF};
        vecs[2] = '{1'b1, 2'd0, 1'b0, 1'b1, 24'hFF0004, 32'h88776655, 32'hFFFFFFFF};
        vecs[3] = '{1'b1, 2'd3, 1'b1, 1'b1, 24'hFF0005, 32'h00887766, 32'h00FFFFFF};
        vecs[4] = '{1'b0, 2'd2, 1'b0, 1'b1, 24'hFF0005, 32'h00887766, 32'h00FFFFFF};
        vecs[5] = '{1'b1, 2'd2, 1'b0, 1'b1, 24'hFF0005, 32'h00887766, 32'h00FFFFFF};
        vecs[6] = '{1'b1, 2'd0, 1'b1, 1'b1, 24'hFF0008, 32'h00000000, 32'h00000000};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset pc", {8'd0, pc}, 32'h00FF0000);
        checkOutput("reset bus_rd", {31'd0, bus_rd}, 32'd0);
        checkOutput("reset mem_busy", {31'd0, mem_busy}, 32'd1);
        checkOutput("reset bus_addr", {8'd0, bus_addr}, 32'h00FF0000);

        // First request straight after reset, then fill with 1-cycle acks
        resp_en   = 1'b1;
        fetch_sel = 2'd3;
        rst       = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("first bus_rd", {31'd0, bus_rd}, 32'd1);
        checkOutput("first bus_addr", {8'd0, bus_addr}, 32'h00FF0000);
        n = 0;
        while (mem_busy !== 1'b0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("fill mem_busy sel3", {31'd0, mem_busy}, 32'd0);
        checkOutput("fill op", op, 32'h44332211);
        checkOutput("fill pc", {8'd0, pc}, 32'h00FF0000);
        repeat (30) @(posedge clk);
        #1;
        resp_en = 1'b0;
        checkOutput("full no request", {31'd0, bus_rd}, 32'd0);
        checkOutput("ack count", n_acks, 32'd4);
        checkOutput("ack addr 0", {8'd0, ack_addr[0]}, 32'h00FF0000);
        checkOutput("ack addr 1", {8'd0, ack_addr[1]}, 32'h00FF0002);
        checkOutput("ack addr 3", {8'd0, ack_addr[3]}, 32'h00FF0006);

        // Pops from a full queue with no further data arriving
        for (int i = 0; i < 7; i++) begin
            inc_pc    = vecs[i].inc;
            fetch_sel = vecs[i].sel;
            #1;
            checkOutput($sformatf("vec%0d mem_busy", i), {31'd0, mem_busy}, {31'd0, vecs[i].exp_busy});
            checkOutput($sformatf("vec%0d bus_rd", i), {31'd0, bus_rd}, {31'd0, vecs[i].exp_rd});
            checkOutput($sformatf("vec%0d pc", i), {8'd0, pc}, {8'd0, vecs[i].exp_pc});
            if (vecs[i].op_mask != 32'd0)
                checkOutput($sformatf("vec%0d op", i), op & vecs[i].op_mask, vecs[i].exp_op);
            @(posedge clk);
            #1;
        end
        inc_pc = 1'b0;

        // Push of 2 and pop of 1 together at count 3
        ackCycle("a1", 24'hFF0008, 16'hAA99, 1'b0, 2'd0);
        ackCycle("a2", 24'hFF000A, 16'hCCBB, 1'b0, 2'd0);
        checkOutput("a2 md", {24'd0, md}, 32'h99);
        applyStimulus(1'b1, 2'd0);
        ackCycle("a3", 24'hFF000C, 16'hEEDD, 1'b1, 2'd0);
        inc_pc    = 1'b0;
        fetch_sel = 2'd3;
        #1;
        checkOutput("overlap mem_busy", {31'd0, mem_busy}, 32'd0);
        checkOutput("overlap op", op, 32'hEEDDCCBB);
        checkOutput("overlap pc", {8'd0, pc}, 32'h00FF000A);
        applyStimulus(1'b1, 2'd3);
        inc_pc    = 1'b0;
        fetch_sel = 2'd0;
        #1;
        checkOutput("drained mem_busy", {31'd0, mem_busy}, 32'd1);
        checkOutput("drained pc", {8'd0, pc}, 32'h00FF000E);

        // Three-byte pop stalls at count 2 until the next push lands
        inc_pc    = 1'b1;
        fetch_sel = 2'd2;
        ackCycle("a4", 24'hFF000E, 16'h5F4E, 1'b1, 2'd2);
        #1;
        checkOutput("stall mem_busy", {31'd0, mem_busy}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("stall pc", {8'd0, pc}, 32'h00FF000E);
        ackCycle("a5", 24'hFF0010, 16'h7160, 1'b1, 2'd2);
        checkOutput("unstall mem_busy", {31'd0, mem_busy}, 32'd0);
        checkOutput("unstall op", op & 32'h00FFFFFF, 32'h00605F4E);
        @(posedge clk);
        #1;
        checkOutput("pop3 pc", {8'd0, pc}, 32'h00FF0011);
        checkOutput("pop3 md", {24'd0, md}, 32'h71);
        inc_pc    = 1'b0;
        fetch_sel = 2'd0;

        // Jump while a read is outstanding; its late data must vanish
        waitBusRd("jump");
        pc_load = 1'b1;
        pc_nx   = 24'h000101;
        @(posedge clk);
        #1;
        pc_load = 1'b0;
        checkOutput("jump pc", {8'd0, pc}, 32'h00000101);
        checkOutput("jump mem_busy", {31'd0, mem_busy}, 32'd1);
        checkOutput("discard bus_addr held", {8'd0, bus_addr}, 32'h00FF0012);
        repeat (2) @(posedge clk);
        #1;
        ackCycle("discard", 24'hFF0012, 16'hDEAD, 1'b0, 2'd0);
        checkOutput("discard dropped", {31'd0, mem_busy}, 32'd1);
        checkOutput("discard bus_rd", {31'd0, bus_rd}, 32'd0);

        // Odd jump target keeps only the high byte of the first word
        ackCycle("odd", 24'h000100, 16'hBBAA, 1'b0, 2'd0);
        checkOutput("odd md", {24'd0, md}, 32'hBB);
        checkOutput("odd pc", {8'd0, pc}, 32'h00000101);
        checkOutput("odd one byte sel0", {31'd0, mem_busy}, 32'd0);
        fetch_sel = 2'd1;
        #1;
        checkOutput("odd one byte sel1", {31'd0, mem_busy}, 32'd1);
        ackCycle("next", 24'h000102, 16'hDDCC, 1'b0, 2'd1);
        checkOutput("next op", op & 32'h00FFFFFF, 32'h00DDCCBB);

        // Jump coinciding with the ack: data dropped, FSM back to idle
        waitBusRd("jump ack");
        pc_load = 1'b1;
        pc_nx   = 24'h123456;
        man_din = 16'h9999;
        man_ack = 1'b1;
        fetch_sel = 2'd0;
        @(posedge clk);
        #1;
        pc_load = 1'b0;
        man_ack = 1'b0;
        checkOutput("jump ack bus_rd", {31'd0, bus_rd}, 32'd0);
        checkOutput("jump ack pc", {8'd0, pc}, 32'h00123456);
        checkOutput("jump ack mem_busy", {31'd0, mem_busy}, 32'd1);
        ackCycle("new target", 24'h123456, 16'h7788, 1'b0, 2'd1);
        checkOutput("new target md", {24'd0, md}, 32'h88);
        checkOutput("new target mem_busy", {31'd0, mem_busy}, 32'd0);

        // Clock enable low freezes the PC
        cen       = 1'b0;
        inc_pc    = 1'b1;
        fetch_sel = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("cen low pc", {8'd0, pc}, 32'h00123456);
        cen = 1'b1;
        @(posedge clk);
        #1;
        inc_pc = 1'b0;
        checkOutput("cen high pc", {8'd0, pc}, 32'h00123457);
        checkOutput("cen high md", {24'd0, md}, 32'h77);

        // Asynchronous reset mid-stream
        rst = 1'b1;
        #1;
        checkOutput("rst pc", {8'd0, pc}, 32'h00FF0000);
        checkOutput("rst bus_rd", {31'd0, bus_rd}, 32'd0);
        checkOutput("rst mem_busy", {31'd0, mem_busy}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
